upe_bit_serializer: RTL and testbench

UPE_BIT_SERIALIZER -- requirements
Module: upe_bit_serializer

---
 rtl/upe_bit_serializer.sv | 127 ++++++++++++
 tb/tb_upe_bit_serializer.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/upe_bit_serializer.sv
`default_nettype none
// ============================================================================
// Module   : upe_bit_serializer
// Purpose  : Serializes a captured upe result word LSB-first onto an LED line,
//            framed by a one-period start marker and a one-period stop gap.
// Revision : 1.0 - initial release
// ============================================================================
module upe_bit_serializer #(
    parameter int WIDTH     = 64,
    parameter int BIT_TICKS = 101
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             led_data,
    output logic             led_tick,
    output logic             busy,
    output logic             done
);

    localparam int TICK_W = (BIT_TICKS > 1) ? $clog2(BIT_TICKS) : 1;
    localparam int CNT_W  = $clog2(WIDTH + 1);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(BIT_TICKS - 1);
    localparam logic [CNT_W-1:0]  BIT_LAST  = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        SHIFT = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [TICK_W-1:0]  tick_q, tick_d;
    logic [CNT_W-1:0]   bit_q, bit_d;
    logic [WIDTH-1:0]   shreg_q, shreg_d;
    logic               led_q, led_d;
    logic               led_tick_q, led_tick_d;
    logic               done_q, done_d;
    logic               period_end;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            tick_q     <= '0;
            bit_q      <= '0;
            shreg_q    <= '0;
            led_q      <= 1'b0;
            led_tick_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            tick_q     <= tick_d;
            bit_q      <= bit_d;
            shreg_q    <= shreg_d;
            led_q      <= led_d;
            led_tick_q <= led_tick_d;
            done_q     <= done_d;
        end
    end

    assign period_end = (tick_q == TICK_LAST);

    always_comb begin
        state_d    = state_q;
        tick_d     = tick_q;
        bit_d      = bit_q;
        shreg_d    = shreg_q;
        led_tick_d = led_tick_q;
        done_d     = 1'b0;

        // Every non-idle state advances the period timer and strobes at its end.
        if (state_q != IDLE) begin
            if (period_end) begin
                tick_d     = '0;
                led_tick_d = ~led_tick_q;
            end else begin
                tick_d = tick_q + TICK_W'(1);
            end
        end

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    shreg_d = in_data;
                    tick_d  = '0;
                    bit_d   = '0;
                    state_d = START;
                end
            end
            START: begin
                if (period_end) state_d = SHIFT;
            end
            SHIFT: begin
                if (period_end) begin
                    shreg_d = shreg_q >> 1;
                    if (bit_q == BIT_LAST) begin
                        bit_d   = '0;
                        state_d = STOP;
                    end else begin
                        bit_d = bit_q + CNT_W'(1);
                    end
                end
            end
            STOP: begin
                if (period_end) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // LED level is registered from the upcoming state so it never glitches.
        led_d = (state_d == START) || ((state_d == SHIFT) && shreg_d[0]);
    end

    assign in_ready = (state_q == IDLE);
    assign busy     = (state_q != IDLE);
    assign led_data = led_q;
    assign led_tick = led_tick_q;
    assign done     = done_q;

endmodule
`default_nettype wire

// File: tb/tb_upe_bit_serializer.sv
`default_nettype none
// ============================================================================
// Module   : tb_upe_bit_serializer
// Purpose  : Self-checking bench for upe_bit_serializer (BIT_TICKS=4 and =1).
// Revision : 1.0 - initial release
// ============================================================================
module tb_upe_bit_serializer;

    localparam int W  = 64;
    localparam int BT = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic [W-1:0] in_data;
    logic         in_ready, led_data, led_tick, busy, done;

    logic         in1_valid;
    logic [W-1:0] in1_data;
    logic         in1_ready, led1_data, led1_tick, busy1, done1;

    int   checks = 0;
    int   errors = 0;
    logic m_tick = 1'b0;

    always #5 clk = ~clk;

    upe_bit_serializer #(.WIDTH(W), .BIT_TICKS(BT)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .led_data (led_data),
        .led_tick (led_tick),
        .busy     (busy),
        .done     (done)
    );

    upe_bit_serializer #(.WIDTH(W), .BIT_TICKS(1)) dut1 (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in1_valid),
        .in_data  (in1_data),
        .in_ready (in1_ready),
        .led_data (led1_data),
        .led_tick (led1_tick),
        .busy     (busy1),
        .done     (done1)
    );

    // Caller presents in_valid=1/in_data=d before calling; the next edge accepts.
    // Expected waveform: 1 for a period, data bits LSB-first, 0 for a period,
    // done in the first idle cycle. Input is scrambled while the frame runs.
    task automatic run_frame(input logic [W-1:0] d, input logic nv,
                             input logic [W-1:0] nd, input string tag);
        int   n = (W + 2) * BT;
        int   toggles = 0;
        logic prev_tick = m_tick;
        logic exp_led, exp_tick;
        for (int j = 0; j <= n; j++) begin
            @(posedge clk); #1;
            if (j < BT)                exp_led = 1'b1;
            else if (j < (W + 1) * BT) exp_led = d[j / BT - 1];
            else                       exp_led = 1'b0;
            exp_tick = m_tick ^ logic'((j / BT) % 2);
            checks++;
            if (led_data !== exp_led) begin
                errors++;
                $display("FAIL %s led_data j=%0d got %b exp %b", tag, j, led_data, exp_led);
            end
            checks++;
            if (led_tick !== exp_tick) begin
                errors++;
                $display("FAIL %s led_tick j=%0d got %b exp %b", tag, j, led_tick, exp_tick);
            end
            checks++;
            if (done !== (j == n)) begin
                errors++;
                $display("FAIL %s done j=%0d got %b exp %b", tag, j, done, (j == n));
            end
            checks++;
            if (busy !== (j < n) || in_ready !== (j == n)) begin
                errors++;
                $display("FAIL %s busy/in_ready j=%0d got %b/%b exp %b/%b",
                         tag, j, busy, in_ready, (j < n), (j == n));
            end
            if (led_tick !== prev_tick) toggles++;
            prev_tick = led_tick;
            if (j < n) begin
                in_valid = 1'($urandom);
                in_data  = {$urandom, $urandom};
            end else begin
                in_valid = nv;
                in_data  = nd;
            end
        end
        checks++;
        if (toggles != W + 2) begin
            errors++;
            $display("FAIL %s tick_toggles got %0d exp %0d", tag, toggles, W + 2);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b1; in_data = '1;
        in1_valid = 1'b0; in1_data = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({led_data, led_tick, done, busy, in_ready} !== 5'b00001) begin
            errors++;
            $display("FAIL reset outputs got %b exp 00001",
                     {led_data, led_tick, done, busy, in_ready});
        end
        @(negedge clk);
        rst = 1'b0; in_valid = 1'b0;
        m_tick = 1'b0;
    endtask

    task automatic test_idle();
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            checks++;
            if ({led_data, led_tick, done, busy, in_ready} !== 5'b00001) begin
                errors++;
                $display("FAIL idle outputs i=%0d got %b exp 00001", i,
                         {led_data, led_tick, done, busy, in_ready});
            end
        end
    endtask

    task automatic test_known_word();
        in_valid = 1'b1; in_data = 64'h0000_007F_FF3C_F7D7;
        run_frame(64'h0000_007F_FF3C_F7D7, 1'b0, '0, "known");
    endtask

    task automatic test_patterns();
        logic [W-1:0] d;
        for (int k = 0; k < 5; k++) begin
            d = (k == 0) ? '1 : (k == 1) ? '0 : {$urandom, $urandom};
            in_valid = 1'b1; in_data = d;
            run_frame(d, 1'b0, '0, "pattern");
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] a, b, c;
        a = {$urandom, $urandom}; b = {$urandom, $urandom}; c = {$urandom, $urandom};
        in_valid = 1'b1; in_data = a;
        run_frame(a, 1'b1, b, "b2b_a");
        run_frame(b, 1'b1, c, "b2b_b");
        run_frame(c, 1'b0, '0, "b2b_c");
    endtask

    task automatic test_mid_frame_reset();
        logic [W-1:0] d, e;
        d = {$urandom, $urandom}; e = {$urandom, $urandom};
        in_valid = 1'b1; in_data = d;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat ((1 + 20) * BT) @(posedge clk);
        #2;
        checks++;
        if (busy !== 1'b1 || led_data !== d[20]) begin
            errors++;
            $display("FAIL pre_reset busy/led got %b/%b exp 1/%b", busy, led_data, d[20]);
        end
        rst = 1'b1;
        #1;
        checks++;
        if ({led_data, led_tick, done, busy, in_ready} !== 5'b00001) begin
            errors++;
            $display("FAIL async_reset outputs got %b exp 00001",
                     {led_data, led_tick, done, busy, in_ready});
        end
        @(negedge clk);
        rst = 1'b0;
        m_tick = 1'b0;
        in_valid = 1'b1; in_data = e;
        run_frame(e, 1'b0, '0, "after_reset");
    endtask

    task automatic test_bt1();
        logic [W-1:0] d = 64'h8000_0000_0000_0001;
        logic         exp_led;
        in1_valid = 1'b1; in1_data = d;
        for (int j = 0; j <= W + 2; j++) begin
            @(posedge clk); #1;
            in1_valid = 1'b0; in1_data = {$urandom, $urandom};
            if (j == 0)          exp_led = 1'b1;
            else if (j <= W)     exp_led = d[j - 1];
            else                 exp_led = 1'b0;
            checks++;
            if (led1_data !== exp_led || done1 !== (j == W + 2) ||
                led1_tick !== logic'(j % 2)) begin
                errors++;
                $display("FAIL bt1 j=%0d led/done/tick got %b/%b/%b exp %b/%b/%b",
                         j, led1_data, done1, led1_tick, exp_led, (j == W + 2), logic'(j % 2));
            end
        end
    endtask

    initial begin
        test_reset();
        test_idle();
        test_known_word();
        test_patterns();
        test_back_to_back();
        test_mid_frame_reset();
        test_bt1();
        repeat (2) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
